// File: rtl/pll_ctrl_pkg.sv
// Shared types for the PLL power-up/recovery sequencer.
package pll_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 3'd0,
    RESET_HOLD = 3'd1,
    WAIT_LOCK  = 3'd2,
    STABLE     = 3'd3,
    RUN        = 3'd4,
    FAIL       = 3'd5,
    FAULT      = 3'd6
  } state_t;

endpackage

// File: rtl/pll_ctrl_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_ctrl.sv
// Power-up and recovery sequencer for one PLL: reset hold, lock wait with
// timeout, lock qualification, bounded retry, and gated output enables.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | PLL disabled and in reset, retry count cleared
// RESET_HOLD | PLL enabled, resetn held low for RESET_CYCLES
// WAIT_LOCK  | resetn released, waiting for lock up to LOCK_TIMEOUT
// STABLE     | lock seen, requiring STABLE_CYCLES consecutive lock cycles
// RUN        | locked; requested (masked) outputs enabled
// FAIL       | one-cycle retry decision, PLL held in reset
// FAULT      | retries exhausted; PLL off until enable drops
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int         RESET_CYCLES  = 16,
  parameter int         LOCK_TIMEOUT  = 4096,
  parameter int         STABLE_CYCLES = 256,
  parameter int         MAX_RETRIES   = 3,
  parameter logic [3:0] CLKOUT_MASK   = 4'b0011,
  parameter int         CNT_W         = 16
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               enable,
  input  logic [3:0]         clkout_req,
  input  logic               pll_lock,
  output logic               pll_pllen,
  output logic               pll_resetn,
  output logic [3:0]         pll_clkouten,
  output logic               ready,
  output logic               fault,
  output logic               lock_lost,
  output logic [3:0]         retry_cnt,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       retry_nxt;
  logic             lock_s;
  logic             lost_nxt;
  logic             pllen_nxt, resetn_nxt, ready_nxt, fault_nxt;
  logic [3:0]       clkouten_nxt;

  sync2 u_lock_sync (
    .clk   (clkin),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    lost_nxt  = 1'b0;
    case (state)
      IDLE: begin
        retry_nxt = '0;
        if (enable) begin
          state_nxt = RESET_HOLD;
          cnt_nxt   = '0;
        end
      end
      RESET_HOLD: begin
        if (cnt == RESET_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = FAIL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STABLE: begin
        // any lock dropout restarts both the timeout and qualification
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = FAIL;
          lost_nxt  = 1'b1;
        end
      end
      FAIL: begin
        cnt_nxt = '0;
        if (retry_cnt >= RETRY_MAX) begin
          state_nxt = FAULT;
        end else begin
          state_nxt = RESET_HOLD;
          retry_nxt = retry_cnt + 4'd1;
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      retry_nxt = '0;
      lost_nxt  = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_comb begin
    pllen_nxt    = 1'b0;
    resetn_nxt   = 1'b0;
    ready_nxt    = 1'b0;
    fault_nxt    = 1'b0;
    clkouten_nxt = 4'b0000;
    case (state_nxt)
      RESET_HOLD, FAIL: pllen_nxt = 1'b1;
      WAIT_LOCK, STABLE: begin
        pllen_nxt  = 1'b1;
        resetn_nxt = 1'b1;
      end
      RUN: begin
        pllen_nxt    = 1'b1;
        resetn_nxt   = 1'b1;
        ready_nxt    = 1'b1;
        clkouten_nxt = clkout_req & CLKOUT_MASK;
      end
      FAULT: fault_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      retry_cnt    <= '0;
      pll_pllen    <= 1'b0;
      pll_resetn   <= 1'b0;
      pll_clkouten <= 4'b0000;
      ready        <= 1'b0;
      fault        <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      retry_cnt    <= retry_nxt;
      pll_pllen    <= pllen_nxt;
      pll_resetn   <= resetn_nxt;
      pll_clkouten <= clkouten_nxt;
      ready        <= ready_nxt;
      fault        <= fault_nxt;
      lock_lost    <= lost_nxt;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_ctrl.sv
// Directed bench for pll_ctrl with short timing parameters; edge numbers in
// the comments count from the edge that first samples enable=1.
module tb_pll_ctrl;

  logic       clkin = 1'b0;
  logic       reset, enable, pll_lock;
  logic [3:0] clkout_req;
  logic       pll_pllen, pll_resetn, ready, fault, lock_lost;
  logic [3:0] pll_clkouten, retry_cnt;
  logic [2:0] state_o;

  int n_vec = 0;
  int n_err = 0;

  pll_ctrl #(
    .RESET_CYCLES  (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .CLKOUT_MASK   (4'b0011),
    .CNT_W         (16)
  ) dut (
    .clkin        (clkin),
    .reset        (reset),
    .enable       (enable),
    .clkout_req   (clkout_req),
    .pll_lock     (pll_lock),
    .pll_pllen    (pll_pllen),
    .pll_resetn   (pll_resetn),
    .pll_clkouten (pll_clkouten),
    .ready        (ready),
    .fault        (fault),
    .lock_lost    (lock_lost),
    .retry_cnt    (retry_cnt),
    .state_o      (state_o)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".state"},  32'(state_o),      32'd0);
    check({tag, ".pllen"},  32'(pll_pllen),    32'd0);
    check({tag, ".resetn"}, 32'(pll_resetn),   32'd0);
    check({tag, ".clkoen"}, 32'(pll_clkouten), 32'd0);
    check({tag, ".ready"},  32'(ready),        32'd0);
    check({tag, ".fault"},  32'(fault),        32'd0);
    check({tag, ".lost"},   32'(lock_lost),    32'd0);
    check({tag, ".retry"},  32'(retry_cnt),    32'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; pll_lock = 1'b0; clkout_req = 4'h0;
    tick(2);
    check_reset_vals("rst");
    reset = 1'b0;
    tick(1);

    // Clean bring-up
    enable = 1'b1; clkout_req = 4'hF;
    tick(1);                                        // edge 0
    check("t1.st0", 32'(state_o), 32'd1);
    check("t1.pllen0", 32'(pll_pllen), 32'd1);
    check("t1.rstn0", 32'(pll_resetn), 32'd0);
    tick(3);                                        // edge 3
    check("t1.rstn3", 32'(pll_resetn), 32'd0);
    tick(1);                                        // edge 4
    check("t1.rstn4", 32'(pll_resetn), 32'd1);
    check("t1.st4", 32'(state_o), 32'd2);
    tick(5);                                        // edge 9
    pll_lock = 1'b1;
    tick(2);                                        // edge 11: lock_s just rose
    check("t1.st11", 32'(state_o), 32'd2);
    tick(1);                                        // edge 12
    check("t1.st12", 32'(state_o), 32'd3);
    tick(7);                                        // edge 19
    check("t1.st19", 32'(state_o), 32'd3);
    check("t1.rdy19", 32'(ready), 32'd0);
    tick(1);                                        // edge 20
    check("t1.st20", 32'(state_o), 32'd4);
    check("t1.rdy20", 32'(ready), 32'd1);
    check("t1.coe20", 32'(pll_clkouten), 32'h3);
    check("t1.retry", 32'(retry_cnt), 32'd0);

    // Output request tracking in RUN
    clkout_req = 4'b0001;
    tick(1);
    check("t5.coe_a", 32'(pll_clkouten), 32'h1);
    clkout_req = 4'b0110;
    check("t5.coe_hold", 32'(pll_clkouten), 32'h1);
    tick(1);
    check("t5.coe_b", 32'(pll_clkouten), 32'h2);

    // Lock loss in RUN; edges below are E0 = now
    pll_lock = 1'b0;
    tick(2);                                        // E2
    check("t3.rdy2", 32'(ready), 32'd1);
    check("t3.lost2", 32'(lock_lost), 32'd0);
    tick(1);                                        // E3
    check("t3.lost3", 32'(lock_lost), 32'd1);
    check("t3.rdy3", 32'(ready), 32'd0);
    check("t3.coe3", 32'(pll_clkouten), 32'h0);
    check("t3.st3", 32'(state_o), 32'd5);
    tick(1);                                        // E4
    check("t3.lost4", 32'(lock_lost), 32'd0);
    check("t3.st4", 32'(state_o), 32'd1);
    check("t3.retry4", 32'(retry_cnt), 32'd1);
    tick(1);                                        // E5
    pll_lock = 1'b1;
    tick(3);                                        // E8
    check("t3.st8", 32'(state_o), 32'd2);
    tick(1);                                        // E9: STABLE, counter 0
    check("t3.st9", 32'(state_o), 32'd3);

    // One-cycle lock dropout seen while STABLE counter is 5
    tick(3);                                        // E12
    pll_lock = 1'b0;
    tick(1);                                        // E13
    pll_lock = 1'b1;
    tick(1);                                        // E14
    check("t4.st14", 32'(state_o), 32'd3);
    tick(1);                                        // E15
    check("t4.st15", 32'(state_o), 32'd2);
    tick(1);                                        // E16
    check("t4.st16", 32'(state_o), 32'd3);
    tick(7);                                        // E23
    check("t4.st23", 32'(state_o), 32'd3);
    check("t4.rdy23", 32'(ready), 32'd0);
    tick(1);                                        // E24
    check("t4.st24", 32'(state_o), 32'd4);
    check("t4.rdy24", 32'(ready), 32'd1);
    check("t4.retry", 32'(retry_cnt), 32'd1);

    // Disable from RUN, then exhaust retries with no lock
    enable = 1'b0; pll_lock = 1'b0;
    tick(1);
    check("t2.idle_st", 32'(state_o), 32'd0);
    check("t2.idle_rty", 32'(retry_cnt), 32'd0);
    check("t2.idle_coe", 32'(pll_clkouten), 32'h0);
    check("t2.idle_rdy", 32'(ready), 32'd0);
    check("t2.idle_pen", 32'(pll_pllen), 32'd0);
    tick(3);
    enable = 1'b1;
    tick(1);                                        // edge 0
    check("t2.st0", 32'(state_o), 32'd1);
    tick(23);                                       // edge 23
    check("t2.st23", 32'(state_o), 32'd2);
    tick(1);                                        // edge 24
    check("t2.st24", 32'(state_o), 32'd5);
    check("t2.pen24", 32'(pll_pllen), 32'd1);
    check("t2.rstn24", 32'(pll_resetn), 32'd0);
    tick(1);                                        // edge 25
    check("t2.st25", 32'(state_o), 32'd1);
    check("t2.rty25", 32'(retry_cnt), 32'd1);
    tick(49);                                       // edge 74
    check("t2.st74", 32'(state_o), 32'd5);
    check("t2.rty74", 32'(retry_cnt), 32'd2);
    tick(1);                                        // edge 75
    check("t2.st75", 32'(state_o), 32'd6);
    check("t2.flt75", 32'(fault), 32'd1);
    check("t2.pen75", 32'(pll_pllen), 32'd0);
    check("t2.rty75", 32'(retry_cnt), 32'd2);
    tick(5);
    check("t2.st_hold", 32'(state_o), 32'd6);
    enable = 1'b0;
    tick(1);
    check("t2.clr_st", 32'(state_o), 32'd0);
    check("t2.clr_rty", 32'(retry_cnt), 32'd0);
    check("t2.clr_flt", 32'(fault), 32'd0);

    // Reset during WAIT_LOCK, then enable drop during RESET_HOLD
    enable = 1'b1;
    tick(6);                                        // edge 5
    check("t6.st5", 32'(state_o), 32'd2);
    check("t6.rstn5", 32'(pll_resetn), 32'd1);
    reset = 1'b1;
    tick(1);
    check_reset_vals("t6.rst");
    reset = 1'b0;
    tick(2);
    check("t6.st_rh", 32'(state_o), 32'd1);
    check("t6.pen_rh", 32'(pll_pllen), 32'd1);
    enable = 1'b0;
    tick(1);
    check("t6.off_st", 32'(state_o), 32'd0);
    check("t6.off_pen", 32'(pll_pllen), 32'd0);
    check("t6.off_rstn", 32'(pll_resetn), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pll_ctrl.md
Name: pll_ctrl

Overview:
Power-up and recovery sequencer for one alta_pllx PLL instance. It holds the PLL in reset, releases it, waits for lock with a timeout, and qualifies lock stability before gating the per-output clock enables. On lock loss or timeout it retries a bounded number of times, then latches a fault. It runs on the PLL reference clock and drives the pllen, resetn and clkoutNen pins of the PLL wrapper.

Parameters:
RESET_CYCLES, 16, cycles pll_resetn is held low per attempt (>=1)
LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before an attempt fails (>=2)
STABLE_CYCLES, 256, consecutive synchronized-lock-high cycles required before RUN (>=1)
MAX_RETRIES, 3, failed attempts tolerated before FAULT (0..15)
CLKOUT_MASK, 4'b0011, static mask of PLL outputs that may ever be enabled
CNT_W, 16, width of the shared cycle counter; must hold max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)

Ports:
clkin  in  1  reference clock; the block's only clock
reset  in  1  synchronous, active-high reset
enable  in  1  level request to bring the PLL up; deassert to shut down or clear a fault
clkout_req  in  4  per-output enable requests from clock consumers
pll_lock  in  1  raw PLL lock, asynchronous to clkin
pll_pllen  out  1  to PLL pllen
pll_resetn  out  1  to PLL resetn, active low
pll_clkouten  out  4  to PLL clkout0en..clkout3en
ready  out  1  high while in RUN
fault  out  1  high while in FAULT
lock_lost  out  1  one-cycle pulse when lock drops in RUN
retry_cnt  out  4  failed attempts since the last IDLE
state_o  out  3  current state encoding, for debug

Behaviour:
- Decided interface: one clock, clkin. Reset is synchronous and active-high on port reset.
- All outputs are registered.
- Reset values: pll_pllen=0, pll_resetn=0, pll_clkouten=0, ready=0, fault=0, lock_lost=0, retry_cnt=0, state=IDLE, counter=0.
- pll_lock passes through a 2-flop synchronizer (lock_s), adding 2 cycles of latency. Synchronizer flops reset to 0.
- States and outputs:
  - IDLE: pllen=0, resetn=0, clkouten=0. retry_cnt cleared. enable=1 -> RESET_HOLD with counter=0.
  - RESET_HOLD: pllen=1, resetn=0. Counter increments. At counter==RESET_CYCLES-1 -> WAIT_LOCK with counter=0.
  - WAIT_LOCK: pllen=1, resetn=1. Counter increments.
    - lock_s=1 -> STABLE with counter=0.
    - Otherwise, counter==LOCK_TIMEOUT-1 -> FAIL.
  - STABLE: pllen=1, resetn=1.
    - lock_s=0 -> WAIT_LOCK with counter=0; the timeout restarts.
    - counter==STABLE_CYCLES-1 with lock_s=1 -> RUN.
  - RUN: ready=1. pll_clkouten <= clkout_req & CLKOUT_MASK, registered with 1-cycle latency.
    - lock_s=0 -> FAIL. On that transition edge: clkouten=0, ready=0, lock_lost=1 for 1 cycle.
  - FAIL (transient, one cycle): pllen=1, resetn=0, clkouten=0.
    - retry_cnt==MAX_RETRIES -> FAULT.
    - Otherwise retry_cnt+=1 -> RESET_HOLD with counter=0.
  - FAULT: pllen=0, resetn=0, clkouten=0, fault=1. Remains until enable=0, then -> IDLE.
- enable=0 has priority in every state: next state is IDLE and all enables drop on the same edge.
- pll_clkouten is nonzero only in RUN; masked bits are always 0.
- retry_cnt saturates at MAX_RETRIES and never wraps.
- Reset asserted mid-sequence returns to reset values on the next edge. The PLL is re-held in reset (resetn=0).
- Lock glitches shorter than 1 clkin cycle may be missed. That is acceptable.

Decomposition:
- Package pll_ctrl_pkg: state enum (IDLE=0, RESET_HOLD=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAIL=5, FAULT=6) and the 3-bit state width constant.
- One sub-module, sync2 (2-flop synchronizer, synchronous active-high reset), used for pll_lock.
- A single shared counter is reused across RESET_HOLD, WAIT_LOCK and STABLE.

Test Plan:
Bench parameters: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Reset, then enable=1 at edge 0, pll_lock=1 from edge 10, clkout_req=4'b1111 -> pll_resetn rises at edge 4; ready=1 and pll_clkouten=4'b0011 after lock sync plus 8 stable cycles; retry_cnt=0.
2. pll_lock held 0 -> three timeouts (retry_cnt 1, 2, then FAULT); fault=1, pllen=0; enable=0 -> IDLE next edge, retry_cnt=0.
3. In RUN, drop pll_lock for 5 cycles -> lock_lost single pulse, clkouten=0 and ready=0 at the same edge, retry_cnt=1, RESET_HOLD re-entered.
4. In STABLE, lock drops at counter=5 -> WAIT_LOCK with counter restarted; RUN reached only after 8 fresh consecutive lock cycles.
5. In RUN, toggle clkout_req 4'b0001 -> 4'b0110 -> pll_clkouten follows one cycle later as 4'b0001 then 4'b0010.
6. Assert reset during WAIT_LOCK, then enable=0 mid-RESET_HOLD -> all outputs return to reset values on the next edge in both cases.
